// File: rtl/cla_pkg.sv
// Shared constants, stage-1 payload layout and the 4-bit carry-lookahead equations
// used by the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam int CLA_GROUP      = 4;
  localparam int CLA_MAX_WIDTH  = 64;
  localparam int CLA_MAX_GROUPS = CLA_MAX_WIDTH / CLA_GROUP;

  // Sized for the widest legal adder; narrower builds keep the upper bits at zero.
  typedef struct packed {
    logic [CLA_MAX_WIDTH-1:0]  p;
    logic [CLA_MAX_WIDTH-1:0]  g;
    logic [CLA_MAX_GROUPS-1:0] gp;
    logic [CLA_MAX_GROUPS-1:0] gg;
    logic                      c_eff;
    logic                      sign;
    logic                      sub;
  } s1_payload_t;

  typedef struct packed {
    logic [3:0] c;
    logic       pg;
    logic       gg;
  } la4_t;

  // c[i] is the carry into bit i; pg/gg are the group propagate/generate terms.
  function automatic la4_t lookahead4(input logic [3:0] p, input logic [3:0] g, input logic ci);
    la4_t r;
    r.c[0] = ci;
    r.c[1] = g[0] | (p[0] & ci);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.pg   = &p;
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// Combinational 4-bit lookahead cell: bit carries plus group propagate/generate.
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);

  la4_t la;

  assign la = lookahead4(p, g, ci);
  assign c  = la.c;
  assign pg = la.pg;
  assign gg = la.gg;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake;
// stage 1 captures p/g and group terms, stage 2 resolves carries and registers sum and flags.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl,
  output logic             zero
);

  localparam int NG  = WIDTH / CLA_GROUP;
  localparam int NSG = (NG + 3) / 4;

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < 4 || WIDTH > CLA_MAX_WIDTH || GROUP != CLA_GROUP) begin : g_bad_param
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64 and GROUP must be 4");
  end

  logic             s1_valid_r;
  s1_payload_t      s1_r;
  s1_payload_t      s1_next_s;
  la4_t             grp_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             s1_adv_s;
  logic             s2_adv_s;

  assign s2_adv_s = ~out_valid | out_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign in_ready = s1_adv_s;

  // Operand conditioning and per-group propagate/generate for the stage-1 register
  always_comb begin
    s1_next_s = '0;
    grp_s     = '0;
    b_eff_s   = sub ? ~b : b;
    s1_next_s.p[WIDTH-1:0] = a ^ b_eff_s;
    s1_next_s.g[WIDTH-1:0] = a & b_eff_s;
    for (int j = 0; j < NG; j++) begin
      grp_s = lookahead4(s1_next_s.p[4*j +: 4], s1_next_s.g[4*j +: 4], 1'b0);
      s1_next_s.gp[j] = grp_s.pg;
      s1_next_s.gg[j] = grp_s.gg;
    end
    s1_next_s.c_eff = sub ? 1'b1 : cin;
    s1_next_s.sign  = sign;
    s1_next_s.sub   = sub;
  end

  // Stage-1 pipeline register; payload only loads on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_r <= s1_next_s;
      end
    end
  end

  // Padding groups propagate, so the last second-level cell's carry out is the adder carry out.
  logic [4*NSG-1:0] gp_pad_s;
  logic [4*NSG-1:0] gg_pad_s;
  logic [4*NSG-1:0] gc_s;
  logic [WIDTH-1:0] bc_s;
  logic [NG-1:0]    bpg_s;
  logic [NG-1:0]    bgg_s;
  logic             cout_s;
  logic [WIDTH-1:0] sum_s;
  logic             ofl_s;

  // Group terms padded up to a whole number of second-level cells
  always_comb begin
    gp_pad_s         = '1;
    gg_pad_s         = '0;
    gp_pad_s[NG-1:0] = s1_r.gp[NG-1:0];
    gg_pad_s[NG-1:0] = s1_r.gg[NG-1:0];
  end

  for (genvar k = 0; k < NSG; k++) begin : g_l2
    logic ci_k;
    logic pg_k;
    logic gg_k;
    logic co_k;
    if (k == 0) begin : g_first
      assign ci_k = s1_r.c_eff;
    end else begin : g_next
      assign ci_k = g_l2[k-1].co_k;
    end
    cla_lookahead4 u_l2 (
      .p  (gp_pad_s[4*k +: 4]),
      .g  (gg_pad_s[4*k +: 4]),
      .ci (ci_k),
      .c  (gc_s[4*k +: 4]),
      .pg (pg_k),
      .gg (gg_k)
    );
    assign co_k = gg_k | (pg_k & ci_k);
  end

  for (genvar j = 0; j < NG; j++) begin : g_l1
    cla_lookahead4 u_l1 (
      .p  (s1_r.p[4*j +: 4]),
      .g  (s1_r.g[4*j +: 4]),
      .ci (gc_s[j]),
      .c  (bc_s[4*j +: 4]),
      .pg (bpg_s[j]),
      .gg (bgg_s[j])
    );
  end

  assign cout_s = g_l2[NSG-1].co_k;
  assign sum_s  = s1_r.p[WIDTH-1:0] ^ bc_s;
  assign ofl_s  = s1_r.sign ? (bc_s[WIDTH-1] ^ cout_s) : (cout_s ^ s1_r.sub);

  // Group terms recomputed by the bit cells and padding bits are not needed downstream.
  logic unused_bits;
  assign unused_bits = ^{grp_s, bpg_s, bgg_s, gc_s, s1_r};

  // Output register; holds its value while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ofl       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        sum  <= sum_s;
        cout <= cout_s;
        ofl  <= ofl_s;
        zero <= ~|sum_s;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, handshake corner sequences and
// random regressions at WIDTH 4, 16 and 64 against an arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sign;
    logic [15:0] s;
    logic        co;
    logic        of;
    logic        z;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        rnd_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ofl;
  logic        zero;

  int   checks;
  int   failures;
  int   n_out;
  exp_t sb_q[$];

  cla_pipe_adder #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ofl       (ofl),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: plain wide addition; signed overflow from operand/result sign bits.
  function automatic exp_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic ci, input logic sb, input logic sg, input int w);
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [64:0] full;
    exp_t        r;
    mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa     = a_in & mask;
    bb     = (sb ? ~b_in : b_in) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    if (sg) r.ofl = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    else    r.ofl = r.cout ^ sb;
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  // One cycle on the 16-bit DUT: inputs were set at the falling edge by the caller.
  task automatic step(input exp_t e, output bit acc);
    exp_t x;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      chk("out_has_expectation", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        chk("sum",  64'(sum),  x.sum);
        chk("cout", 64'(cout), 64'(x.cout));
        chk("ofl",  64'(ofl),  64'(x.ofl));
        chk("zero", 64'(zero), 64'(x.zero));
      end
    end
    if (acc) sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    exp_t dmy;
    bit   acc;
    dmy       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(dmy, acc);
    chk({nm, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Wider/narrower random regressions run alongside on their own instances.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 4 : 64;
    logic         iv, ir, ov, ordy, ci, sb, sg, co, of, zr;
    logic [W-1:0] ra, rb, rs;
    bit           done;

    cla_pipe_adder #(.WIDTH(W)) u_rnd (
      .clk       (clk),
      .rst_n     (rnd_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .cin       (ci),
      .sub       (sb),
      .sign      (sg),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (rs),
      .cout      (co),
      .ofl       (of),
      .zero      (zr)
    );

    initial begin
      exp_t        q[$];
      exp_t        x;
      int          issued;
      bit          pend;
      logic [63:0] ta, tb;
      done = 1'b0; iv = 1'b0; ordy = 1'b0; ci = 1'b0; sb = 1'b0; sg = 1'b0;
      ra = '0; rb = '0; ta = '0; tb = '0;
      issued = 0; pend = 1'b0;
      repeat (8) @(negedge clk);
      for (int cyc = 0; cyc < 3000 && (issued < 300 || q.size() != 0); cyc++) begin
        ordy = ($urandom_range(0, 9) < 7);
        if (!pend && issued < 300 && $urandom_range(0, 9) < 7) begin
          ta = {$urandom, $urandom};
          tb = ($urandom_range(0, 7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
          ci = 1'($urandom); sb = 1'($urandom); sg = 1'($urandom);
          pend = 1'b1;
        end
        iv = pend; ra = ta[W-1:0]; rb = tb[W-1:0];
        #1;
        if (ov && ordy) begin
          chk($sformatf("w%0d_has_expectation", W), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            x = q.pop_front();
            chk($sformatf("w%0d_sum", W),  64'(rs), x.sum);
            chk($sformatf("w%0d_flags", W), {61'd0, co, of, zr}, {61'd0, x.cout, x.ofl, x.zero});
          end
        end
        if (iv && ir) begin
          q.push_back(model(64'(ra), 64'(rb), ci, sb, sg, W));
          pend = 1'b0;
          issued++;
        end
        @(posedge clk);
        @(negedge clk);
      end
      chk($sformatf("w%0d_issued", W), 64'(issued), 64'd300);
      chk($sformatf("w%0d_drained", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    vec_t        tbl[12];
    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    exp_t        e;
    bit          acc;
    int          k, issued, out0;
    bit          pend;

    checks = 0; failures = 0; n_out = 0;
    rst_n = 1'b0; rnd_rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sign = 1'b0;

    //             a         b         cin   sub   sign  sum       cout  ofl   zero
    tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    bp_a[0] = 16'h0011; bp_b[0] = 16'h0100;
    bp_a[1] = 16'h0022; bp_b[1] = 16'h0200;
    bp_a[2] = 16'h0033; bp_b[2] = 16'h0300;
    bp_a[3] = 16'h0044; bp_b[3] = 16'h0400;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_flags",     {61'd0, cout, ofl, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rnd_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // directed vectors streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b;
      cin = tbl[i].cin; sub = tbl[i].sub; sign = tbl[i].sign;
      e.sum = 64'(tbl[i].s); e.cout = tbl[i].co; e.ofl = tbl[i].of; e.zero = tbl[i].z;
      step(e, acc);
      chk("table_accept", 64'(acc), 64'd1);
    end
    drain("table");
    chk("table_outputs", 64'(n_out), 64'd12);

    // latency: two edges from accept to out_valid
    in_valid = 1'b1; a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; sign = 1'b0;
    step(model(64'(a), 64'(b), cin, sub, sign, 16), acc);
    chk("lat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    #1 chk("lat_cycle1_idle", 64'(out_valid), 64'd0);
    step(e, acc);
    #1 chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain("latency");

    // backpressure: consumer stalls for 3 cycles, junk offered while not ready
    k = 0; out0 = n_out;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      if (k < 4) begin
        in_valid = 1'b1; a = bp_a[k]; b = bp_b[k]; cin = 1'b1; sub = 1'b0; sign = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (cyc == 2) begin
        a = ~bp_a[k];
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepts_before_stall", 64'(k), 64'd2);
      end
      step(model(64'(a), 64'(b), cin, sub, sign, 16), acc);
      if (acc) k++;
    end
    drain("bp");
    chk("bp_outputs", 64'(n_out - out0), 64'd4);

    // asynchronous reset with two operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h00AA; b = 16'h0055; cin = 1'b0; sub = 1'b0; sign = 1'b0;
    step(model(64'(a), 64'(b), cin, sub, sign, 16), acc);
    a = 16'h1111;
    step(model(64'(a), 64'(b), cin, sub, sign, 16), acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum",       64'(sum),       64'd0);
    chk("midrst_flags",     {61'd0, cout, ofl, zero}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("midrst_no_stale", 64'(out_valid), 64'd0);
      step(e, acc);
    end

    // random regression at WIDTH=16 with random valid/ready
    issued = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 3000 && issued < 300; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!pend && $urandom_range(0, 9) < 7) begin
        a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom); sign = 1'($urandom);
        pend = 1'b1;
      end
      in_valid = pend;
      step(model(64'(a), 64'(b), cin, sub, sign, 16), acc);
      if (acc) begin
        pend = 1'b0;
        issued++;
      end
    end
    chk("rnd16_issued", 64'(issued), 64'd300);
    drain("rnd16");

    for (int i = 0; i < 20000 && !(g_rnd[0].done && g_rnd[1].done); i++) @(negedge clk);
    chk("rnd_wide_done", {62'd0, g_rnd[1].done, g_rnd[0].done}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
